// File: rtl/pio_in_debounce_irq_pkg.sv
// Shared constants for the debounced edge-capture input PIO.
// Register addresses and counter sizing helper.
package pio_in_debounce_irq_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_RISE   = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_FALL   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;

  function automatic int cnt_w(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input channel: synchroniser chain, tick-based stability
// counter and the debounced level flop.
module pio_debounce_bit
  import pio_in_debounce_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 4,
  parameter int CNT_W       = cnt_w(STABLE_CNT)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  input  logic bypass_i,
  input  logic tick_i,
  input  logic clr_i,
  output logic db_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   db_q, db_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end
  end

  assign sync    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Period writes restart the count but hold the accepted level.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (bypass_i) begin
      db_d = sync;
    end else if (tick_i) begin
      if (sync == db_q) begin
        cnt_d = '0;
      end else if (cnt_inc == CNT_W'(STABLE_CNT)) begin
        cnt_d = '0;
        db_d  = sync;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/pio_in_debounce_irq.sv
// Avalon-MM input PIO with per-bit debounce, rise/fall select,
// write-1-to-clear edge capture and a single masked interrupt.
module pio_in_debounce_irq
  import pio_in_debounce_irq_pkg::*;
#(
  parameter int                  WIDTH        = 4,
  parameter int                  SYNC_STAGES  = 2,
  parameter int                  PERIOD_W     = 16,
  parameter logic [PERIOD_W-1:0] PERIOD_RESET = '0,
  parameter int                  STABLE_CNT   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CNT_W = cnt_w(STABLE_CNT);

  logic                wr_en;
  logic                wr_rise, wr_mask, wr_edge;
  logic                wr_fall, wr_period;
  logic [WIDTH-1:0]    db, db_dly_q;
  logic [WIDTH-1:0]    rise_q, fall_q, mask_q;
  logic [WIDTH-1:0]    edge_q, edge_d, clr;
  logic [WIDTH-1:0]    rise, fall;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic                bypass, tick;
  logic [31:0]         rdata_q, rdata_d;
  logic                unused_wdata;

  assign unused_wdata = ^writedata;

  assign wr_en     = chipselect && !write_n;
  assign wr_rise   = wr_en && (address == ADDR_RISE);
  assign wr_mask   = wr_en && (address == ADDR_MASK);
  assign wr_edge   = wr_en && (address == ADDR_EDGE);
  assign wr_fall   = wr_en && (address == ADDR_FALL);
  assign wr_period = wr_en && (address == ADDR_PERIOD);

  // Shared tick prescaler; idle while debounce is bypassed.
  assign bypass = (period_q == '0);
  assign tick   = !bypass && (pcnt_q == period_q);

  always_comb begin
    pcnt_d = pcnt_q + PERIOD_W'(1);
    if (wr_period || bypass || tick) begin
      pcnt_d = '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CNT  (STABLE_CNT),
      .CNT_W       (CNT_W)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_i     (in_port[i]),
      .bypass_i (bypass),
      .tick_i   (tick),
      .clr_i    (wr_period),
      .db_o     (db[i])
    );
  end

  assign rise = db & ~db_dly_q & rise_q;
  assign fall = ~db & db_dly_q & fall_q;
  assign clr  = wr_edge ? writedata[WIDTH-1:0] : '0;

  // A new edge on the same cycle as its clear must survive.
  assign edge_d = (edge_q & ~clr) | rise | fall;

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:   rdata_d[WIDTH-1:0]    = db;
      ADDR_RISE:   rdata_d[WIDTH-1:0]    = rise_q;
      ADDR_MASK:   rdata_d[WIDTH-1:0]    = mask_q;
      ADDR_EDGE:   rdata_d[WIDTH-1:0]    = edge_q;
      ADDR_FALL:   rdata_d[WIDTH-1:0]    = fall_q;
      ADDR_PERIOD: rdata_d[PERIOD_W-1:0] = period_q;
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q   <= '0;
      fall_q   <= '0;
      mask_q   <= '0;
      period_q <= PERIOD_RESET;
      pcnt_q   <= '0;
      edge_q   <= '0;
      db_dly_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (wr_rise)   rise_q   <= writedata[WIDTH-1:0];
      if (wr_fall)   fall_q   <= writedata[WIDTH-1:0];
      if (wr_mask)   mask_q   <= writedata[WIDTH-1:0];
      if (wr_period) period_q <= writedata[PERIOD_W-1:0];
      pcnt_q   <= pcnt_d;
      edge_q   <= edge_d;
      db_dly_q <= db;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Randomised and directed bench for pio_in_debounce_irq with a
// delay-line reference model for bypass mode.
module tb_pio_in_debounce_irq;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int PW = 16;
  localparam int SC = 4;
  localparam logic [PW-1:0] PR = '0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pio_in_debounce_irq #(
    .WIDTH        (W),
    .SYNC_STAGES  (S),
    .PERIOD_W     (PW),
    .PERIOD_RESET (PR),
    .STABLE_CNT   (SC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bypass-mode model: debounced level is in_port delayed by
  // S+1 clock edges; edges are differences along that delay line.
  logic [W-1:0]  h [0:S+1];
  logic [W-1:0]  m_rise, m_fall, m_mask, m_cap;
  logic [PW-1:0] m_per;
  logic [31:0]   m_rdata;
  wire           m_wr = chipselect && !write_n;

  function automatic logic [31:0] m_mux(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0]  = h[S];
      3'd1: r[W-1:0]  = m_rise;
      3'd2: r[W-1:0]  = m_mask;
      3'd3: r[W-1:0]  = m_cap;
      3'd4: r[W-1:0]  = m_fall;
      3'd5: r[PW-1:0] = m_per;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= S + 1; i++) h[i] <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_mask  <= '0;
      m_cap   <= '0;
      m_per   <= PR;
      m_rdata <= '0;
    end else begin
      h[0] <= in_port;
      for (int i = 1; i <= S + 1; i++) h[i] <= h[i-1];
      m_rdata <= m_mux(address);
      if (m_wr && address == 3'd1) m_rise <= writedata[W-1:0];
      if (m_wr && address == 3'd2) m_mask <= writedata[W-1:0];
      if (m_wr && address == 3'd4) m_fall <= writedata[W-1:0];
      if (m_wr && address == 3'd5) m_per  <= writedata[PW-1:0];
      m_cap <= (m_cap & ~((m_wr && address == 3'd3) ?
                          writedata[W-1:0] : {W{1'b0}}))
             | (h[S] & ~h[S+1] & m_rise)
             | (~h[S] & h[S+1] & m_fall);
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("cyc_rdata", readdata, m_rdata);
      check("cyc_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    r          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [31:0] r;
  logic [2:0]  a;
  bit          seen;
  int          n;

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd(3'(i), r);
      check($sformatf("reset_rd%0d", i), r,
            (i == 5) ? 32'(PR) : 32'd0);
    end
    check("reset_irq", {31'b0, irq}, 32'd0);

    wr(3'd1, 32'hF);
    wr(3'd2, 32'h1);
    @(negedge clk) in_port = 4'h1;
    repeat (4) @(negedge clk);
    rd(3'd3, r);
    check("byp_rise_cap", r, 32'h1);
    check("byp_rise_irq", {31'b0, irq}, 32'd1);
    wr(3'd3, 32'h1);
    rd(3'd3, r);
    check("byp_w1c_cap", r, 32'h0);
    check("byp_w1c_irq", {31'b0, irq}, 32'd0);

    wr(3'd1, 32'h0);
    wr(3'd4, 32'h4);
    @(negedge clk) in_port = 4'h4;
    repeat (6) @(negedge clk);
    wr(3'd3, 32'hF);
    rd(3'd3, r);
    check("fall_pre", r, 32'h0);
    @(negedge clk) in_port = 4'h0;
    repeat (6) @(negedge clk);
    rd(3'd3, r);
    check("fall_cap", r, 32'h4);
    wr(3'd3, 32'hF);
    @(negedge clk) in_port = 4'h4;
    repeat (6) @(negedge clk);
    rd(3'd3, r);
    check("fall_no_rise", r, 32'h0);

    wr(3'd4, 32'hC);
    @(negedge clk) in_port = 4'hC;
    repeat (6) @(negedge clk);
    wr(3'd3, 32'hF);
    @(negedge clk) in_port = 4'h0;
    repeat (6) @(negedge clk);
    rd(3'd3, r);
    check("w1c_setup", r, 32'hC);
    wr(3'd2, 32'h8);
    check("w1c_irq_on", {31'b0, irq}, 32'd1);
    wr(3'd3, 32'h4);
    rd(3'd3, r);
    check("w1c_partial", r, 32'h8);
    check("w1c_irq_keep", {31'b0, irq}, 32'd1);
    wr(3'd2, 32'h4);
    check("w1c_irq_off", {31'b0, irq}, 32'd0);

    wr(3'd3, 32'hF);
    wr(3'd1, 32'h1);
    @(negedge clk) in_port = 4'h1;
    repeat (3) @(negedge clk);
    address    = 3'd3;
    writedata  = 32'h1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd(3'd3, r);
    check("race_set_wins", r, 32'h1);

    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        in_port = in_port ^ W'($urandom);
      a = 3'($urandom_range(0, 6));
      if (a == 3'd5) a = 3'd7;
      address    = a;
      writedata  = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;

    in_port = '0;
    repeat (8) @(negedge clk);
    wr(3'd3, 32'hF);
    wr(3'd1, 32'h1);
    wr(3'd4, 32'h0);
    chk_en = 1'b0;
    wr(3'd5, 32'd9);
    rd(3'd5, r);
    check("db_period", r, 32'd9);

    address = 3'd0;
    seen    = 1'b0;
    @(negedge clk) in_port = 4'h1;
    repeat (25) begin
      @(negedge clk);
      if (readdata[0]) seen = 1'b1;
    end
    in_port = 4'h0;
    repeat (60) begin
      @(negedge clk);
      if (readdata[0]) seen = 1'b1;
    end
    check("db_short_data", {31'b0, seen}, 32'd0);
    rd(3'd3, r);
    check("db_short_cap", r, 32'h0);

    address = 3'd0;
    @(negedge clk) in_port = 4'h1;
    n = 0;
    while (readdata[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("db_long_lat", {31'b0, (n >= 30 && n <= 50)}, 32'd1);
    if (n < 60) repeat (60 - n) @(negedge clk);
    in_port = 4'h0;
    repeat (100) @(negedge clk);
    rd(3'd3, r);
    check("db_long_cap", r, 32'h1);
    rd(3'd0, r);
    check("db_long_back", r, 32'h0);

    @(negedge clk) in_port = 4'h1;
    repeat (15) @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    rd(3'd5, r);
    check("rst_mid_period", r, 32'(PR));
    repeat (5) @(negedge clk);
    rd(3'd0, r);
    check("rst_mid_data", r, 32'h1);
    rd(3'd3, r);
    check("rst_mid_cap", r, 32'h0);
    check("rst_mid_irq", {31'b0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_in_debounce_irq.md
Name: pio_in_debounce_irq

Overview:
- Parametrised successor to the 4-bit edge-capture input PIO on the Avalon-MM bus (motor-control sensor and limit-switch inputs).
- Adds configurable width and a configurable synchroniser depth.
- Adds a runtime-programmable debounce filter and a separate rising/falling edge select per bit.
- Adds a write-1-to-clear edge-capture register, so software no longer clears every bit at once. Single IRQ output to the HPS/Nios.

Parameters:
WIDTH, 4, number of input channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
PERIOD_W, 16, width of debounce tick-period register
PERIOD_RESET, 0, reset value of period register (0 = debounce bypassed)
STABLE_CNT, 4, consecutive differing ticks required to accept a new level (2..15)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
address  in  3  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write, active low
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  interrupt, active high

Behaviour:
- Clock and reset: clk is the clock; reset_n is asynchronous, active-low. All flops reset.
- Reset values:
  - readdata, irq, sync chain, debounced value, irq_mask, rise_en, fall_en, edge_capture, counters: 0.
  - period: PERIOD_RESET.
- Register map (bits above WIDTH or PERIOD_W read 0, ignored on write):
  - 0 data: RO, debounced value.
  - 1 rise_en: RW.
  - 2 irq_mask: RW.
  - 3 edge_capture: read; write 1 clears that bit.
  - 4 fall_en: RW.
  - 5 period: RW.
  - 6, 7: read 0, writes ignored.
- Reads: readdata is registered every cycle from the address mux (1-cycle read latency, independent of chipselect). Reads have no side effects.
- Writes: take effect at the clk edge where chipselect && !write_n.
- Synchroniser: SYNC_STAGES flops per bit; sync = last stage.
- Tick prescaler (shared):
  - Counter counts 0..period, then wraps; tick = 1 on the wrap cycle.
  - A write to period resets the counter to 0.
- Bypass mode (period == 0): debounced <= sync every clk, with no counter activity.
- Debounce mode (period > 0), per bit on each tick:
  - If sync != debounced: cnt++.
  - If sync == debounced: cnt <= 0.
  - When cnt would reach STABLE_CNT: debounced <= sync and cnt <= 0.
  - Any glitch shorter than STABLE_CNT ticks is rejected.
- Switching modes: writing period clears all per-bit cnt; debounced is held.
- Edge detect: db_d = debounced delayed one clk.
  - rise = debounced & ~db_d & rise_en.
  - fall = ~debounced & db_d & fall_en.
- edge_capture[i]:
  - Set on rise[i] | fall[i].
  - Cleared by a write to addr 3 with writedata[i] = 1.
  - Simultaneous set and clear on the same bit: set wins (no lost event).
- irq = |(edge_capture & irq_mask), combinational from registers.
- Input latency (bypass): in_port change -> edge_capture bit set after SYNC_STAGES+2 clk edges.
- Reset release with in_port high: debounced rises after sync/debounce, so the edge is captured if rise_en is already set. Since rise_en resets to 0, nothing is captured unless software enables it first.
- Reset asserted mid-count: all state returns to reset values immediately.

Decomposition:
- Shared package:
  - Address constants ADDR_DATA=0, ADDR_RISE=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_FALL=4, ADDR_PERIOD=5.
  - Function for CNT_W = clog2(STABLE_CNT+1).
- One sub-module pio_debounce_bit: sync chain + per-bit counter + debounced flop. Generated WIDTH times.
- Prescaler, registers and edge logic stay in the top module.

Test Plan:
- Reset then read all addresses:
  - Response: readdata 0 for addr 0-4, 6, 7; addr 5 returns PERIOD_RESET; irq 0.
- Bypass, WIDTH=4: write rise_en=0xF, mask=0x1; drive in_port 0->0x1.
  - Response: edge_capture reads 0x1 after ≤4 clk; irq=1.
  - Then write 0x1 to addr 3: capture 0, irq 0.
- Falling only: fall_en=0x4, rise_en=0.
  - in_port bit2 1->0: capture 0x4.
  - in_port bit2 0->1: no capture.
- W1C: capture=0xC; write 0x4 to addr 3.
  - Response: capture=0x8, irq follows mask.
- Set-vs-clear race: align a rising edge on bit0 with a W1C write of 0x1 on the same cycle.
  - Response: capture[0] remains 1.
- Debounce: period=9, STABLE_CNT=4.
  - 25-clk pulse (<4 ticks): data stays 0, no capture.
  - 60-clk pulse: data=1 after 40±10 clk; exactly one rise captured.
